uart_tx_fifo: RTL

- Sink end of the debug character stream: accepts 8-bit ASCII characters on a valid/busy handshake, buffers them in a FIFO, and serializes them onto an 8N1 UART TX line.
- Sits between the debug print controller and the board UART pin.
- Drives the `busy` back-pressure signal that the producer uses to gate its valid and advance its character counter.

---
 rtl/uart_tx_fifo.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Debug character sink: buffers ASCII characters in a FIFO and shifts them out
// as 8N1 frames on a registered UART TX line.
module uart_tx_fifo #(
  parameter int unsigned CLK_DIV    = 868,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            char_in,
  input  logic                  char_valid,
  output logic                  busy,
  output logic                  tx,
  output logic                  tx_idle,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  err_overflow
);

  localparam int unsigned       Depth     = 1 << DEPTH_LOG2;
  localparam logic [15:0]       BaudMax   = 16'(CLK_DIV - 1);
  localparam logic [DEPTH_LOG2:0] LevelFull = (DEPTH_LOG2 + 1)'(Depth);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic [7:0]            mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  state_e                state_q, state_d;
  logic [15:0]           baud_q, baud_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [7:0]            shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  err_q;
  logic                  push, pop, baud_done, fifo_empty;

  // busy comes only from the registered level, so valid = active & ~busy has no loop.
  assign busy       = (level_q == LevelFull);
  assign fifo_empty = (level_q == '0);
  assign push       = char_valid & ~busy;
  assign baud_done  = (baud_q == BaudMax);

  assign tx           = tx_q;
  assign tx_idle      = (state_q == StIdle) && fifo_empty;
  assign fifo_level   = level_q;
  assign err_overflow = err_q;

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          shift_d = mem_q[rptr_q];
          pop     = 1'b1;
          baud_d  = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (baud_done) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = StData;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      StData: begin
        if (baud_done) begin
          baud_d    = '0;
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = StStop;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      StStop: begin
        if (baud_done) begin
          baud_d = '0;
          // Reload straight from the stop bit so queued frames run back to back.
          if (!fifo_empty) begin
            shift_d = mem_q[rptr_q];
            pop     = 1'b1;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      level_q   <= level_d;
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      if (char_valid && busy) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wptr_q] <= char_in;
  end

endmodule
